// File: rtl/ssd_pkg.sv
// ssd_pkg: seven-segment codes {a..g} (active-low) and the nibble-to-segment lookup
package ssd_pkg;
  localparam logic [6:0] SSD_SEG_0 = 7'b0000001;
  localparam logic [6:0] SSD_SEG_1 = 7'b1001111;
  localparam logic [6:0] SSD_SEG_2 = 7'b0010010;
  localparam logic [6:0] SSD_SEG_3 = 7'b0000110;
  localparam logic [6:0] SSD_SEG_4 = 7'b1001100;
  localparam logic [6:0] SSD_SEG_5 = 7'b0100100;
  localparam logic [6:0] SSD_SEG_6 = 7'b0100000;
  localparam logic [6:0] SSD_SEG_7 = 7'b0001111;
  localparam logic [6:0] SSD_SEG_8 = 7'b0000000;
  localparam logic [6:0] SSD_SEG_9 = 7'b0000100;
  localparam logic [6:0] SSD_SEG_A = 7'b0001000;
  localparam logic [6:0] SSD_SEG_B = 7'b1100000;
  localparam logic [6:0] SSD_SEG_C = 7'b0110001;
  localparam logic [6:0] SSD_SEG_D = 7'b1000010;
  localparam logic [6:0] SSD_SEG_E = 7'b0110000;
  localparam logic [6:0] SSD_SEG_F = 7'b0111000;
  localparam logic [6:0] SSD_SEG_DASH = 7'b1111110;
  localparam logic [6:0] SSD_SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SSD_SEG_0;
      4'h1: return SSD_SEG_1;
      4'h2: return SSD_SEG_2;
      4'h3: return SSD_SEG_3;
      4'h4: return SSD_SEG_4;
      4'h5: return SSD_SEG_5;
      4'h6: return SSD_SEG_6;
      4'h7: return SSD_SEG_7;
      4'h8: return SSD_SEG_8;
      4'h9: return SSD_SEG_9;
      4'hA: return SSD_SEG_A;
      4'hB: return SSD_SEG_B;
      4'hC: return SSD_SEG_C;
      4'hD: return SSD_SEG_D;
      4'hE: return SSD_SEG_E;
      default: return SSD_SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: shift-add-3 converter, one bit per clock; Bcd holds the final result while Done pulses
module bin_to_bcd_seq #(
  parameter int VAL_W = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [VAL_W-1:0]        Bin,
  output logic                    Busy,
  output logic                    Done,
  output logic [4*NUM_DIGITS-1:0] Bcd
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int CW = $clog2(VAL_W+1);
  logic [DW-1:0] bcd_q, adj;
  logic [VAL_W-1:0] sh;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  // next step's value, so the last step can be consumed in the cycle Busy falls
  assign Bcd = {adj[DW-2:0], sh[VAL_W-1]};
  assign Done = Busy && cnt == CW'(1);
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      Busy <= 1'b0;
      cnt <= '0;
      bcd_q <= '0;
      sh <= '0;
    end else if (Busy) begin
      bcd_q <= Bcd;
      sh <= sh << 1;
      cnt <= cnt - 1'b1;
      Busy <= cnt != CW'(1);
    end else if (Start) begin
      Busy <= 1'b1;
      cnt <= CW'(VAL_W);
      bcd_q <= '0;
      sh <= Bin;
    end
endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed N-digit seven-segment driver showing a value in hex or decimal
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W = 14,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BLANK_CYC = 16
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [VAL_W-1:0]      Value,
  input  logic                  Load,
  input  logic                  Mode,
  input  logic                  Lz_Blank,
  input  logic [NUM_DIGITS-1:0] Digit_En,
  input  logic [NUM_DIGITS-1:0] Dp_Mask,
  output logic                  Busy,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Cathodes
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned DEC_LIM = 64'd10 ** NUM_DIGITS;
  logic [DW-1:0] disp, bcd, wr_val;
  logic [NUM_DIGITS-1:0] blank, wr_blank;
  logic ovf, pend_ovf, start, done, wr, wr_ovf, z;
  logic [SCAN_DIV_BITS-1:0] pre;
  logic [IW-1:0] idx;
  logic [VAL_W+DW-1:0] val_ext;
  assign val_ext = {{DW{1'b0}}, Value};
  assign start = Load && !Busy && Mode;
  assign wr = done || (Load && !Busy && !Mode);
  assign wr_val = done ? bcd : val_ext[DW-1:0];
  assign wr_ovf = done ? pend_ovf : |val_ext[VAL_W+DW-1:DW];
  bin_to_bcd_seq #(.VAL_W(VAL_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .Clk(Clk),
    .reset(reset),
    .Start(start),
    .Bin(Value),
    .Busy(Busy),
    .Done(done),
    .Bcd(bcd)
  );
  // a digit blanks only when it and every digit to its left are zero; digit 0 always shows
  always_comb begin
    z = 1'b1;
    wr_blank = '0;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      z = z && wr_val[4*k +: 4] == 4'd0;
      wr_blank[k] = z && Lz_Blank && !wr_ovf;
    end
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      pre <= '0;
      idx <= '0;
      disp <= '0;
      blank <= '0;
      ovf <= 1'b0;
      pend_ovf <= 1'b0;
      An <= '1;
      Cathodes <= 8'hFF;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) idx <= idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1;
      if (start) pend_ovf <= 64'(Value) >= DEC_LIM;
      if (wr) begin
        disp <= wr_val;
        blank <= wr_blank;
        ovf <= wr_ovf;
      end
      An <= pre < SCAN_DIV_BITS'(BLANK_CYC) ? '1 : ~(Digit_En & ~blank & (NUM_DIGITS'(1) << idx));
      Cathodes <= {ovf ? SSD_SEG_DASH : hex_to_seg(disp[4*idx +: 4]), ~Dp_Mask[idx]};
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of scan timing, hex/decimal display, blanking, overflow and reset
module tb_ssd_scan_driver;
  logic Clk = 1'b0, reset = 1'b1, Load = 1'b0, Mode = 1'b0, Lz_Blank = 1'b0, Busy;
  logic [13:0] Value = '0;
  logic [3:0] Digit_En = 4'hF, Dp_Mask = 4'h0, An;
  logic [7:0] Cathodes;
  int vec = 0, miss = 0, t = 0, n;
  logic [7:0] hex_exp [4] = '{8'b01100011, 8'b00001101, 8'b00010001, 8'b10011111};
  ssd_scan_driver #(.NUM_DIGITS(4), .VAL_W(14), .SCAN_DIV_BITS(4), .BLANK_CYC(2)) dut (
    .Clk(Clk), .reset(reset), .Value(Value), .Load(Load), .Mode(Mode), .Lz_Blank(Lz_Blank),
    .Digit_En(Digit_En), .Dp_Mask(Dp_Mask), .Busy(Busy), .An(An), .Cathodes(Cathodes)
  );
  always #5 Clk = ~Clk;
  // clocks since reset release; outputs after clock t reflect prescaler (t-1)%16, digit ((t-1)/16)%4
  always @(posedge Clk or posedge reset)
    if (reset) t <= 0;
    else t <= t + 1;
  task automatic tick(input int k = 1);
    repeat (k) @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic seek(input int d);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = t >= 1 && (t-1) % 16 == 8 && ((t-1) / 16) % 4 == d;
    end
    vec++;
    assert (ok) else begin
      miss++;
      $error("FAIL seek: digit %0d slot observed %0d expected 1", d, ok);
    end
  endtask
  task automatic load(input logic [13:0] v, input logic m);
    Value = v;
    Mode = m;
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask
  initial begin
    tick(3);
    chk("rst_an", An, 4'hF);
    chk("rst_cath", Cathodes, 8'hFF);
    chk("rst_busy", Busy, 1'b0);
    reset = 1'b0;
    chk("scan_t0", An, 4'hF);
    tick();
    chk("scan_t1", An, 4'hF);
    tick();
    chk("scan_t2", An, 4'hF);
    tick();
    chk("scan_t3", An, 4'b1110);
    chk("zero_cath", Cathodes, 8'b00000011);
    seek(1); chk("scan_d1", An, 4'b1101);
    seek(2); chk("scan_d2", An, 4'b1011);
    seek(3); chk("scan_d3", An, 4'b0111);
    seek(0); chk("scan_wrap", An, 4'b1110);
    load(14'h1A3C, 1'b0);
    chk("hex_busy", Busy, 1'b0);
    for (int d = 3; d >= 0; d--) begin
      seek(d);
      chk($sformatf("hex_d%0d", d), Cathodes, hex_exp[d]);
    end
    Lz_Blank = 1'b1;
    load(14'd42, 1'b1);
    chk("dec_busy_on", Busy, 1'b1);
    wait_done(n);
    chk("dec_busy_len", 8'(n), 8'd14);
    seek(0); chk("dec42_d0", Cathodes, 8'b00100101); chk("dec42_an0", An, 4'b1110);
    seek(1); chk("dec42_d1", Cathodes, 8'b10011001); chk("dec42_an1", An, 4'b1101);
    seek(2); chk("dec42_an2", An, 4'b1111);
    seek(3); chk("dec42_an3", An, 4'b1111);
    load(14'd0, 1'b1);
    wait_done(n);
    seek(0); chk("dec0_d0", Cathodes, 8'b00000011); chk("dec0_an0", An, 4'b1110);
    seek(1); chk("dec0_an1", An, 4'b1111);
    load(14'd12345, 1'b1);
    wait_done(n);
    for (int d = 0; d < 4; d++) begin
      seek(d);
      chk($sformatf("ovf_d%0d", d), Cathodes, 8'b11111101);
    end
    chk("ovf_an3", An, 4'b0111);
    load(14'd9999, 1'b1);
    wait_done(n);
    seek(0); chk("dec9999_d0", Cathodes, 8'b00001001);
    seek(3); chk("dec9999_d3", Cathodes, 8'b00001001); chk("dec9999_an3", An, 4'b0111);
    load(14'd42, 1'b1);
    n = 0;
    while (Busy && n < 40) begin
      Load = n == 2;
      if (n == 2) Value = 14'd7;
      n++;
      tick();
    end
    Load = 1'b0;
    chk("ign_busy_len", 8'(n), 8'd14);
    seek(0); chk("ign_d0", Cathodes, 8'b00100101);
    seek(1); chk("ign_d1", Cathodes, 8'b10011001);
    seek(2); chk("ign_an2", An, 4'b1111);
    load(14'd42, 1'b1);
    tick(4);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_an", An, 4'hF);
    Digit_En = 4'b1011;
    Dp_Mask = 4'b0100;
    Lz_Blank = 1'b0;
    tick();
    reset = 1'b0;
    tick(3);
    chk("post_rst_an0", An, 4'b1110);
    seek(0); chk("post_d0", Cathodes, 8'b00000011);
    seek(1); chk("post_d1", Cathodes, 8'b00000011); chk("post_an1", An, 4'b1101);
    seek(2); chk("post_d2", Cathodes, 8'b00000010); chk("post_an2", An, 4'b1111);
    seek(3); chk("post_d3", Cathodes, 8'b00000011); chk("post_an3", An, 4'b0111);
    chk("post_busy", Busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
